dmem_responder: RTL and testbench

//   Memory-side responder for the MEM-stage data port of the pipelined RV32I core.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/constants.svh | 12 +
 rtl/load_align.sv | 27 ++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and funct3 decode helpers for the data-memory responder.
package mem_pkg;
  `include "constants.svh"

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction
endpackage

// File: rtl/constants.svh
// RV32I load/store funct3 encodings shared by the data-memory path.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH
localparam logic [2:0] F3_LB  = 3'b000;
localparam logic [2:0] F3_LH  = 3'b001;
localparam logic [2:0] F3_LW  = 3'b010;
localparam logic [2:0] F3_LBU = 3'b100;
localparam logic [2:0] F3_LHU = 3'b101;
localparam logic [2:0] F3_SB  = 3'b000;
localparam logic [2:0] F3_SH  = 3'b001;
localparam logic [2:0] F3_SW  = 3'b010;
`endif

// File: rtl/load_align.sv
// Selects the addressed byte/half/word from an aligned 4-byte group and extends it.
module load_align
  import mem_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [3:0][7:0]    raw,
  input  logic [1:0]         boff,
  input  logic [2:0]         funct3,
  output logic [DWIDTH-1:0]  data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = raw[boff];
    h = boff[1] ? {raw[3], raw[2]} : {raw[1], raw[0]};
    case (funct3)
      F3_LB:   data = {{(DWIDTH-8){b[7]}}, b};
      F3_LH:   data = {{(DWIDTH-16){h[15]}}, h};
      F3_LW:   data = DWIDTH'(raw);
      F3_LBU:  data = {{(DWIDTH-8){1'b0}}, b};
      F3_LHU:  data = {{(DWIDTH-16){1'b0}}, h};
      default: data = '0;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data port responder: one request in flight, fixed latency, byte array.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter int                MEM_DEPTH = 1048576,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
  parameter int                LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [AWIDTH:0] LO = {1'b0, BASE_ADDR};
  localparam logic [AWIDTH:0] HI = LO + (AWIDTH+1)'(MEM_DEPTH);

  logic [7:0]        mem [MEM_DEPTH];
  state_e            state;
  logic [3:0]        cnt;
  logic [DWIDTH-1:0] pend_rdata;
  logic              pend_err;

  logic              accept, misal, oor, illegal, err;
  size_e             sz;
  logic [AWIDTH:0]   nbytes;
  logic [IW-1:0]     idx, widx;
  logic [3:0][7:0]   raw;
  logic [DWIDTH-1:0] ld_data, nxt_rdata;

  // Checks use one extra address bit so addr+size near the top cannot wrap.
  always_comb begin
    accept  = req_valid && req_ready;
    sz      = f3_size(req_funct3);
    case (sz)
      SZ_B:    nbytes = (AWIDTH+1)'(1);
      SZ_H:    nbytes = (AWIDTH+1)'(2);
      default: nbytes = (AWIDTH+1)'(4);
    endcase
    misal   = (sz == SZ_H && req_addr[0]) || (sz == SZ_W && req_addr[1:0] != 2'b00);
    oor     = ({1'b0, req_addr} < LO) || (({1'b0, req_addr} + nbytes) > HI);
    illegal = !f3_legal(req_write, req_funct3);
    err     = misal || oor || illegal;
    idx     = IW'(req_addr - BASE_ADDR);
    widx    = {idx[IW-1:2], 2'b00};
  end

  always_comb begin
    for (int i = 0; i < 4; i++) raw[i] = mem[widx | IW'(i)];
  end

  load_align #(.DWIDTH(DWIDTH)) u_align (
    .raw    (raw),
    .boff   (req_addr[1:0]),
    .funct3 (req_funct3),
    .data   (ld_data)
  );

  assign nxt_rdata = (err || req_write) ? '0 : ld_data;

  // Stores commit at the accept edge; reset does not touch the array.
  always_ff @(posedge clk) begin
    if (accept && req_write && !err)
      for (int i = 0; i < 4; i++)
        if ((AWIDTH+1)'(i) < nbytes) mem[idx + IW'(i)] <= req_wdata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      cnt        <= '0;
      pend_rdata <= '0;
      pend_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready  <= 1'b0;
            pend_rdata <= nxt_rdata;
            pend_err   <= err;
            cnt        <= 4'(LATENCY - 1);
            state      <= WAIT;
          end
        end
        // Dwell in WAIT until cnt hits 0 so rsp_valid rises LATENCY edges after accept.
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= pend_rdata;
            rsp_err   <= pend_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized bench for dmem_responder against a byte-map reference model.
module tb_dmem_responder;
  localparam int          DEPTH = 1048576;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h01000000;

  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int ntests = 0, nfail = 0;
  byte unsigned mdl [int unsigned];

  dmem_responder #(
    .AWIDTH(32), .DWIDTH(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV32I load/store semantics over a sparse byte map.
  task automatic model(input bit wr, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                       output bit [31:0] rd, output bit er);
    int n; bit ok; longint la; bit [31:0] v, k;
    ok = 1; n = 4; la = longint'(a); k = a - BASE;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    ok = 0;
    endcase
    if (wr && f3[2]) ok = 0;
    er = !ok || (la % n) != 0 || la < longint'(BASE) || la + n > longint'(BASE) + DEPTH;
    rd = 0;
    if (!er) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mdl[k + 32'(i)] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[k + 32'(i)];
        case (f3)
          3'd0:    rd = {{24{v[7]}}, v[7:0]};
          3'd1:    rd = {{16{v[15]}}, v[15:0]};
          default: rd = v;
        endcase
      end
    end
  endtask

  task automatic do_req(input string tag, input bit wr, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] wd, input int hold, input bit poke, output logic [31:0] got);
    bit [31:0] erd; bit eer; int k; logic [31:0] d0; logic e0;
    got = 'x;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    if (!req_ready) return;
    req_valid = 1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    model(wr, f3, a, wd, erd, eer);
    #1 req_valid = 0;
    k = 0;
    while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    check({tag, "_lat"}, 32'(k), 32'(LAT));
    d0 = rsp_rdata; e0 = rsp_err; got = d0;
    check({tag, "_rdata"}, d0, erd);
    check({tag, "_err"}, 32'(e0), 32'(eer));
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        req_valid = 1; req_write = 1; req_funct3 = 3'b010;
        req_addr = BASE + 32'h10; req_wdata = 32'h0BADF00D;
      end
      @(posedge clk); #1;
      check({tag, "_hold_vld"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, d0);
      check({tag, "_hold_err"}, 32'(rsp_err), 32'(e0));
      check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    bit [31:0] erd; bit eer;
    bit [31:0] a; bit [2:0] f3; bit wr;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdy", 32'(req_ready), 32'd0);
    check("rst_vld", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    reset = 1;

    // Word store/load round trip
    do_req("t1_sw", 1, 3'b010, BASE + 32'h10, 32'hDEADBEEF, 0, 0, got);
    check("t1_ack", got, 32'd0);
    do_req("t1_lw", 0, 3'b010, BASE + 32'h10, 0, 0, 0, got);
    check("t1_val", got, 32'hDEADBEEF);

    // Byte store then sub-word loads
    do_req("t2_sb", 1, 3'b000, BASE + 32'h13, 32'h00000080, 0, 0, got);
    do_req("t2_lb", 0, 3'b000, BASE + 32'h13, 0, 0, 0, got);
    check("t2_lb_val", got, 32'hFFFFFF80);
    do_req("t2_lbu", 0, 3'b100, BASE + 32'h13, 0, 0, 0, got);
    check("t2_lbu_val", got, 32'h00000080);
    do_req("t2_lh", 0, 3'b001, BASE + 32'h12, 0, 0, 0, got);
    check("t2_lh_val", got, 32'hFFFF80AD);

    // Misaligned and illegal funct3
    do_req("t3_sw0", 1, 3'b010, BASE, 32'h11223344, 0, 0, got);
    do_req("t3_lwmis", 0, 3'b010, BASE + 32'h2, 0, 0, 0, got);
    do_req("t3_lhmis", 0, 3'b001, BASE + 32'h1, 0, 0, 0, got);
    do_req("t3_ill_ld", 0, 3'b011, BASE, 0, 0, 0, got);
    do_req("t3_ill_st", 1, 3'b100, BASE, 32'hFFFFFFFF, 0, 0, got);
    do_req("t3_lw", 0, 3'b010, BASE, 0, 0, 0, got);
    check("t3_val", got, 32'h11223344);

    // Range boundaries
    do_req("t4_sw_top", 1, 3'b010, BASE + DEPTH - 4, 32'hCAFEF00D, 0, 0, got);
    do_req("t4_sw_lo", 1, 3'b010, BASE - 4, 32'h12345678, 0, 0, got);
    do_req("t4_sw_hi", 1, 3'b010, BASE + DEPTH - 2, 32'h12345678, 0, 0, got);
    do_req("t4_sh_hi", 1, 3'b001, BASE + DEPTH, 32'h00005555, 0, 0, got);
    do_req("t4_lw_top", 0, 3'b010, BASE + DEPTH - 4, 0, 0, 0, got);
    check("t4_val", got, 32'hCAFEF00D);

    // Backpressure: hold response, poke a store that must not be accepted
    do_req("t5_hold", 0, 3'b010, BASE + 32'h10, 0, 5, 1, got);
    do_req("t5_rb", 0, 3'b010, BASE + 32'h10, 0, 0, 0, got);
    check("t5_val", got, 32'h80ADBEEF);

    // Reset while in WAIT after a committed store
    @(negedge clk);
    check("t6_rdy", 32'(req_ready), 32'd1);
    req_valid = 1; req_write = 1; req_funct3 = 3'b010;
    req_addr = BASE + 32'h20; req_wdata = 32'h5A5AA5A5;
    @(posedge clk);
    model(1, 3'b010, BASE + 32'h20, 32'h5A5AA5A5, erd, eer);
    #1 req_valid = 0;
    reset = 0;
    #1;
    check("t6_vld", 32'(rsp_valid), 32'd0);
    check("t6_rdy_rst", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1;
    do_req("t6_lw", 0, 3'b010, BASE + 32'h20, 0, 0, 0, got);
    check("t6_val", got, 32'h5A5AA5A5);

    // Randomized traffic in a pre-filled window plus edge addresses
    for (int i = 0; i < 16; i++)
      do_req("rnd_fill", 1, 3'b010, BASE + 32'h100 + 32'(4*i), $urandom, 0, 0, got);
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 4));
        1:       a = BASE + DEPTH - 32'($urandom_range(0, 3));
        default: a = BASE + 32'h100 + 32'($urandom_range(0, 63));
      endcase
      do_req("rnd", wr, f3, a, $urandom, $urandom_range(0, 2), 0, got);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
